// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer: one producer, CHANNELS independent
// consumers, each behind a one-entry valid/ready holding slot, plus broadcast.

module dmux_stream_slot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             out_ready,
   output logic             can_accept,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A slot that is draining this edge may be refilled on the same edge.
   assign can_accept = !full_q || out_ready;
   assign out_valid  = full_q;
   assign out_data   = full_q ? data_q : '0;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (wr_en) begin
         full_d = 1'b1;
         data_d = wr_data;
      end else if (full_q && out_ready) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
endmodule

module dmux_stream #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 2,
   parameter int SEL_WIDTH = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in,
   input  logic [SEL_WIDTH-1:0]      sel,
   input  logic                      bcast,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [7:0]                drop_count
);
   localparam logic [SEL_WIDTH:0] CH_LIM = (SEL_WIDTH+1)'(CHANNELS);

   logic [CHANNELS-1:0] can;
   logic [CHANNELS-1:0] wr_en;
   logic                in_range;
   logic                sel_can;
   logic                accept;
   logic [7:0]          drop_count_q, drop_count_d;

   // Out-of-range words are always accepted so they can be counted and dropped.
   always_comb begin
      in_range = ({1'b0, sel} < CH_LIM);
      sel_can  = 1'b0;
      for (int k = 0; k < CHANNELS; k++)
         if (sel == SEL_WIDTH'(k)) sel_can = can[k];
      if (bcast)         in_ready = &can;
      else if (in_range) in_ready = sel_can;
      else               in_ready = 1'b1;
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      wr_en = '0;
      for (int k = 0; k < CHANNELS; k++)
         wr_en[k] = accept && (bcast || (in_range && sel == SEL_WIDTH'(k)));
   end

   always_comb begin
      drop_count_d = drop_count_q;
      if (accept && !bcast && !in_range && drop_count_q != 8'hFF)
         drop_count_d = drop_count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_count_q <= '0;
      else       drop_count_q <= drop_count_d;
   end

   assign drop_count = drop_count_q;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
      dmux_stream_slot #(.WIDTH(WIDTH)) u_slot (
         .clk        (clk),
         .reset      (reset),
         .wr_en      (wr_en[k]),
         .wr_data    (in),
         .out_ready  (out_ready[k]),
         .can_accept (can[k]),
         .out_valid  (out_valid[k]),
         .out_data   (out[k*WIDTH +: WIDTH])
      );
   end
endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: directed cases on 2- and 3-channel builds, then a
// randomized 4-channel run checked by a per-channel scoreboard.

module tb_dmux_stream;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instance A: default 16-bit, 2 channels
   logic [15:0] a_in;  logic a_sel, a_bcast, a_valid, a_ready;
   logic [31:0] a_out; logic [1:0] a_ovalid, a_oready; logic [7:0] a_drop;
   dmux_stream #(.WIDTH(16), .CHANNELS(2), .SEL_WIDTH(1)) u_a (
      .clk(clk), .reset(reset), .in(a_in), .sel(a_sel), .bcast(a_bcast),
      .in_valid(a_valid), .in_ready(a_ready), .out(a_out), .out_valid(a_ovalid),
      .out_ready(a_oready), .drop_count(a_drop));

   // Instance B: 3 channels behind a 2-bit select, exercises drops
   logic [15:0] b_in;  logic [1:0] b_sel; logic b_bcast, b_valid, b_ready;
   logic [47:0] b_out; logic [2:0] b_ovalid, b_oready; logic [7:0] b_drop;
   dmux_stream #(.WIDTH(16), .CHANNELS(3), .SEL_WIDTH(2)) u_b (
      .clk(clk), .reset(reset), .in(b_in), .sel(b_sel), .bcast(b_bcast),
      .in_valid(b_valid), .in_ready(b_ready), .out(b_out), .out_valid(b_ovalid),
      .out_ready(b_oready), .drop_count(b_drop));

   // Instance C: 8-bit, 4 channels, random traffic
   logic [7:0] c_in;   logic [1:0] c_sel; logic c_bcast, c_valid, c_ready;
   logic [31:0] c_out; logic [3:0] c_ovalid, c_oready; logic [7:0] c_drop;
   dmux_stream #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) u_c (
      .clk(clk), .reset(reset), .in(c_in), .sel(c_sel), .bcast(c_bcast),
      .in_valid(c_valid), .in_ready(c_ready), .out(c_out), .out_valid(c_ovalid),
      .out_ready(c_oready), .drop_count(c_drop));

   // Scoreboard: per-channel queue of words the model expects to see, in order.
   logic [7:0] cq [4][$];
   logic       c_mon_en = 1'b0;
   int         pushed = 0;
   int         popped = 0;

   always @(negedge clk) begin
      if (c_mon_en) begin
         for (int k = 0; k < 4; k++) begin
            logic       ev;
            logic [7:0] ed;
            ev = (cq[k].size() != 0);
            ed = ev ? cq[k][0] : 8'h00;
            chk($sformatf("c_valid%0d", k), 64'(c_ovalid[k]), 64'(ev));
            chk($sformatf("c_data%0d", k), 64'(c_out[k*8 +: 8]), 64'(ed));
            if (ev && c_oready[k]) begin
               void'(cq[k].pop_front());
               popped++;
            end
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      a_in = '0; a_sel = '0; a_bcast = 0; a_valid = 0; a_oready = '0;
      b_in = '0; b_sel = '0; b_bcast = 0; b_valid = 0; b_oready = '0;
      c_in = '0; c_sel = '0; c_bcast = 0; c_valid = 0; c_oready = '0;
      #13;
      chk("rst_a_valid", 64'(a_ovalid), 0);
      chk("rst_a_out", 64'(a_out), 0);
      chk("rst_a_drop", 64'(a_drop), 0);
      chk("rst_b_out", 64'(b_out), 0);
      reset = 1'b0;
      #1 chk("rst_a_ready", 64'(a_ready), 1);

      // Unicast into channel 1, consumer stalled
      @(posedge clk); #1;
      a_in = 16'hA5A5; a_sel = 1'b1; a_valid = 1;
      @(negedge clk); chk("a_rdy_empty", 64'(a_ready), 1);
      @(posedge clk); #1; a_valid = 0;
      @(negedge clk);
      chk("a_uni_valid", 64'(a_ovalid), 64'h2);
      chk("a_uni_out", 64'(a_out), 64'hA5A5_0000);
      chk("a_uni_rdy", 64'(a_ready), 0);

      // Simultaneous drain and refill of channel 1
      @(posedge clk); #1;
      a_oready = 2'b10; a_in = 16'h1234; a_valid = 1;
      @(negedge clk); chk("a_pass_rdy", 64'(a_ready), 1);
      @(posedge clk); #1; a_valid = 0; a_oready = 2'b00;
      @(negedge clk);
      chk("a_pass_valid", 64'(a_ovalid), 64'h2);
      chk("a_pass_out", 64'(a_out), 64'h1234_0000);

      // Drain channel 1, then fill channel 0
      @(posedge clk); #1; a_oready = 2'b10;
      @(posedge clk); #1; a_oready = 2'b00; a_in = 16'h1111; a_sel = 1'b0; a_valid = 1;
      @(negedge clk); chk("a_drained", 64'(a_ovalid), 0);
      @(posedge clk); #1; a_bcast = 1; a_in = 16'hBEEF;
      @(negedge clk);
      chk("a_bc_blk_rdy", 64'(a_ready), 0);
      chk("a_bc_blk_out", 64'(a_out), 64'h0000_1111);
      @(posedge clk); #1;
      @(negedge clk);
      chk("a_bc_hold_valid", 64'(a_ovalid), 64'h1);
      chk("a_bc_hold_out", 64'(a_out), 64'h0000_1111);
      a_oready = 2'b01;
      #1 chk("a_bc_rdy", 64'(a_ready), 1);
      @(posedge clk); #1; a_valid = 0; a_bcast = 0; a_oready = 2'b00;
      @(negedge clk);
      chk("a_bc_valid", 64'(a_ovalid), 64'h3);
      chk("a_bc_out", 64'(a_out), 64'hBEEF_BEEF);

      // Out-of-range select on the 3-channel build, with a short pause
      n = 0;
      @(posedge clk); #1; b_sel = 2'd3; b_in = 16'h5555; b_valid = 1;
      for (int i = 0; i < 305; i++) begin
         @(negedge clk);
         chk("b_drop_rdy", 64'(b_ready), 1);
         chk("b_drop_valid", 64'(b_ovalid), 0);
         chk("b_drop_cnt", 64'(b_drop), 64'(n > 255 ? 255 : n));
         @(posedge clk);
         if (b_valid) n++;
         #1 b_valid = !(i >= 99 && i < 104);
         b_in = 16'($urandom);
      end
      b_valid = 0;
      @(negedge clk); chk("b_drop_sat", 64'(b_drop), 255);

      // Randomized traffic with random backpressure
      @(posedge clk); #1; c_mon_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         logic       rdy;
         logic [3:0] tgt;
         c_valid  = ($urandom_range(9) < 7);
         c_bcast  = ($urandom_range(9) == 0);
         c_sel    = 2'($urandom_range(3));
         c_in     = 8'($urandom);
         c_oready = 4'($urandom);
         @(negedge clk); #1;
         // After the monitor has retired this cycle's drains, an empty queue
         // means that channel can take a word on the coming edge.
         tgt = c_bcast ? 4'hF : (4'h1 << c_sel);
         rdy = 1'b1;
         for (int k = 0; k < 4; k++)
            if (tgt[k] && cq[k].size() != 0) rdy = 1'b0;
         chk("c_in_ready", 64'(c_ready), 64'(rdy));
         if (c_valid && rdy)
            for (int k = 0; k < 4; k++)
               if (tgt[k]) begin
                  cq[k].push_back(c_in);
                  pushed++;
               end
         @(posedge clk); #1;
      end
      c_valid = 0; c_oready = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("c_leftover", 64'(cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size()), 0);
      chk("c_count", 64'(popped), 64'(pushed));
      chk("c_nodrop", 64'(c_drop), 0);
      c_mon_en = 1'b0;

      // Asynchronous reset between edges with channels full
      @(posedge clk); #1; c_oready = 4'h0; c_valid = 1; c_bcast = 1; c_in = 8'h3C;
      @(posedge clk); #1; c_valid = 0; c_bcast = 0;
      chk("pre_rst_a_valid", 64'(a_ovalid), 64'h3);
      chk("pre_rst_c_valid", 64'(c_ovalid), 64'hF);
      #2 reset = 1'b1;
      #1;
      chk("arst_a_valid", 64'(a_ovalid), 0);
      chk("arst_a_out", 64'(a_out), 0);
      chk("arst_b_drop", 64'(b_drop), 0);
      chk("arst_c_valid", 64'(c_ovalid), 0);
      chk("arst_c_out", 64'(c_out), 0);
      @(negedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_a_valid", 64'(a_ovalid), 0);
      chk("post_rst_b_drop", 64'(b_drop), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
